// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encodings,
// oversample default and the mid-bit sample index.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int OVERSAMPLE_DEF = 16;
  localparam logic [3:0] MID_IDX = 4'd7;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver line/FIFO-side bundle; master drives the line,
// slave is the receiver side.
interface uart_rx_if;

  logic       rx_bit;
  logic       tick16;
  logic       fifo_full;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  modport master (
    output rx_bit, tick16, fifo_full,
    input  data_out, data_valid,
    input  frame_err, overrun_err, parity_err
  );

  modport slave (
    input  rx_bit, tick16, fifo_full,
    output data_out, data_valid,
    output frame_err, overrun_err, parity_err
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer with a configurable reset value
// for the asynchronous serial line.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff_q <= {STAGES{RST_VAL}};
    else        ff_q <= STAGES'({ff_q, d_i});
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampled 8N1 UART receiver with FIFO overrun detection.
// Define UART_RX_PARITY_EN for an even-parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       tick16,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun_err
);

  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  rx_state_e  state_q;
  logic [3:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic       armed_q;
  logic [7:0] dout_q;
  logic       valid_q;
  logic       ferr_q;
  logic       ovr_q;
  logic       rxs;
`ifdef UART_RX_PARITY_EN
  logic       par_q;
  logic       perr_q;
`endif

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_bit),
    .q_o   (rxs)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (rxs) begin
            armed_q <= 1'b1;
          end else if (tick16 && armed_q) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: if (tick16) begin
          if (cnt_q == MID_IDX) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DATA: if (tick16) begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            sh_q  <= {rxs, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (tick16) begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            par_q   <= rxs;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
`endif
        ST_STOP: if (tick16) begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            if (!rxs) begin
              // Disarm so a held break reports only once.
              ferr_q  <= 1'b1;
              armed_q <= 1'b0;
            end else if (fifo_full) begin
              ovr_q <= 1'b1;
            end else begin
              dout_q  <= sh_q;
              valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q  <= ^{sh_q, par_q};
`endif
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule
